// File: rtl/vga_pkg.sv
// Shared constants and types for the sprite pixel pipeline.
// Covers the 1280x1024 raster and the 38x40 1-bpp sprite ROM geometry.
package vga_pkg;

    localparam int unsigned H_RES   = 1280;
    localparam int unsigned V_RES   = 1024;
    localparam int unsigned SPR_W   = 38;
    localparam int unsigned SPR_H   = 40;
    localparam int unsigned ADDR_W  = 6;
    localparam int unsigned COLOR_W = 12;
    localparam int unsigned COL_W   = 6;

    typedef logic [10:0] coord_t;

    localparam coord_t MAX_X = coord_t'(H_RES - SPR_W);
    localparam coord_t MAX_Y = coord_t'(V_RES - SPR_H);
    localparam coord_t SPR_W_C = coord_t'(SPR_W);
    localparam coord_t SPR_H_C = coord_t'(SPR_H);

    // Clamp a requested position so the whole sprite stays on screen.
    function automatic coord_t sat(input coord_t v, input coord_t lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/sig_delay.sv
// Reset-to-zero shift register delaying a W-bit bus by N clock cycles.
module sig_delay #(
    parameter int unsigned W = 1,
    parameter int unsigned N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stages [N];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < N; i++) stages[i] <= '0;
        end else begin
            stages[0] <= d;
            for (int unsigned i = 1; i < N; i++) stages[i] <= stages[i-1];
        end
    end

    assign q = stages[N-1];

endmodule

// File: rtl/sprite_render.sv
// Two-stage sprite overlay: stage 1 addresses the external sprite ROM, stage 2
// picks the column bit and registers the colour; sprite position is frame-buffered.
module sprite_render
    import vga_pkg::*;
#(
    parameter coord_t             INIT_X    = 11'd621,
    parameter coord_t             INIT_Y    = 11'd492,
    parameter logic [COLOR_W-1:0] SPR_COLOR = 12'hFF0,
    parameter logic [COLOR_W-1:0] BG_COLOR  = 12'h000
) (
    input  logic               clk,
    input  logic               rst,
    input  coord_t             pixel_x,
    input  coord_t             pixel_y,
    input  logic               video_on,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic               frame_tick,
    input  logic               pos_load,
    input  coord_t             pos_x,
    input  coord_t             pos_y,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [0:SPR_W-1]   rom_row,
    output logic [COLOR_W-1:0] rgb,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic               sprite_on
);

    localparam logic [COL_W-1:0] SPR_W_COL = COL_W'(SPR_W);

    coord_t act_x, act_y, pend_x, pend_y;
    coord_t sat_x, sat_y, dx, dy;
    logic   hit_c, hit1, vid1, bit_c;
    logic [COL_W-1:0] col1;
    logic [1:0] sync_q;

    assign sat_x = sat(pos_x, MAX_X);
    assign sat_y = sat(pos_y, MAX_Y);

    // A load coinciding with frame_tick bypasses pending so it is not lost a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_x  <= INIT_X;
            act_y  <= INIT_Y;
            pend_x <= INIT_X;
            pend_y <= INIT_Y;
        end else begin
            if (pos_load) begin
                pend_x <= sat_x;
                pend_y <= sat_y;
            end
            if (frame_tick) begin
                act_x <= pos_load ? sat_x : pend_x;
                act_y <= pos_load ? sat_y : pend_y;
            end
        end
    end

    // The explicit >= compares reject wrapped differences left of / above the box.
    always_comb begin
        dx    = pixel_x - act_x;
        dy    = pixel_y - act_y;
        hit_c = video_on && (pixel_x >= act_x) && (dx < SPR_W_C)
                         && (pixel_y >= act_y) && (dy < SPR_H_C);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr <= '0;
            hit1     <= 1'b0;
            col1     <= '0;
        end else begin
            hit1 <= hit_c;
            col1 <= dx[COL_W-1:0];
            if (hit_c) rom_addr <= dy[ADDR_W-1:0];
        end
    end

    sig_delay #(.W(1), .N(1)) u_vid_dly (
        .clk (clk),
        .rst (rst),
        .d   (video_on),
        .q   (vid1)
    );

    always_comb begin
        bit_c = 1'b0;
        if (col1 < SPR_W_COL) bit_c = rom_row[col1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb       <= '0;
            sprite_on <= 1'b0;
        end else begin
            sprite_on <= hit1 & bit_c;
            if (!vid1)              rgb <= '0;
            else if (hit1 && bit_c) rgb <= SPR_COLOR;
            else                    rgb <= BG_COLOR;
        end
    end

    sig_delay #(.W(2), .N(2)) u_sync_dly (
        .clk (clk),
        .rst (rst),
        .d   ({hsync_in, vsync_in}),
        .q   (sync_q)
    );

    assign hsync_out = sync_q[1];
    assign vsync_out = sync_q[0];

endmodule

// File: tb/tb_sprite_render.sv
// Directed bench for sprite_render with a checkerboard ROM model:
// row a, column c is set when a+c is even.
module tb_sprite_render;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] pixel_x, pixel_y, pos_x, pos_y;
    logic        video_on, hsync_in, vsync_in, frame_tick, pos_load;
    logic [5:0]  rom_addr;
    logic [0:37] rom_row;
    logic [11:0] rgb;
    logic        hsync_out, vsync_out, sprite_on;

    int total = 0;
    int bad   = 0;

    localparam logic [11:0] SPR = 12'hFF0;
    localparam logic [11:0] BG  = 12'h000;

    always #5 clk = ~clk;

    sprite_render dut (
        .clk        (clk),
        .rst        (rst),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .video_on   (video_on),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .frame_tick (frame_tick),
        .pos_load   (pos_load),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .rom_addr   (rom_addr),
        .rom_row    (rom_row),
        .rgb        (rgb),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .sprite_on  (sprite_on)
    );

    always_comb begin
        rom_row = '0;
        for (int c = 0; c < 38; c++) rom_row[c] = ~(rom_addr[0] ^ c[0]);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one pixel, then a blank cycle; check address after 1 edge, colour after 2.
    task automatic probe(input string tag, input logic [10:0] x, input logic [10:0] y,
                         input logic von, input logic chk_addr, input logic [5:0] exp_addr,
                         input logic [11:0] exp_rgb, input logic exp_on);
        pixel_x = x; pixel_y = y; video_on = von;
        step();
        if (chk_addr) check({tag, ".addr"}, 32'(rom_addr), 32'(exp_addr));
        pixel_x = '0; pixel_y = '0; video_on = 1'b0;
        step();
        check({tag, ".rgb"}, 32'(rgb), 32'(exp_rgb));
        check({tag, ".on"}, 32'(sprite_on), 32'(exp_on));
    endtask

    task automatic load(input logic [10:0] x, input logic [10:0] y, input logic tick);
        pos_x = x; pos_y = y; pos_load = 1'b1; frame_tick = tick;
        step();
        pos_load = 1'b0; frame_tick = 1'b0;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    logic hs_hist [$];
    logic vs_hist [$];

    initial begin
        rst = 1'b1; pixel_x = '0; pixel_y = '0; video_on = 1'b0;
        hsync_in = 1'b0; vsync_in = 1'b0; frame_tick = 1'b0;
        pos_load = 1'b0; pos_x = '0; pos_y = '0;
        repeat (3) step();
        check("rst.rgb", 32'(rgb), 32'h0);
        check("rst.on", 32'(sprite_on), 32'h0);
        check("rst.addr", 32'(rom_addr), 32'h0);
        check("rst.hs", 32'(hsync_out), 32'h0);
        rst = 1'b0;
        step();

        // Default position after the first frame tick: box (621..658, 492..531)
        tick();
        probe("init.tl", 11'd621, 11'd492, 1'b1, 1'b1, 6'd0,  SPR, 1'b1);
        probe("init.br", 11'd658, 11'd531, 1'b1, 1'b1, 6'd39, SPR, 1'b1);
        probe("init.l",  11'd620, 11'd492, 1'b1, 1'b0, 6'd0,  BG,  1'b0);
        probe("init.r",  11'd659, 11'd492, 1'b1, 1'b0, 6'd0,  BG,  1'b0);
        probe("init.b",  11'd621, 11'd532, 1'b1, 1'b0, 6'd0,  BG,  1'b0);

        // Load mid-frame stays pending until the tick
        load(11'd100, 11'd200, 1'b0);
        probe("pend.old", 11'd621, 11'd492, 1'b1, 1'b1, 6'd0, SPR, 1'b1);
        tick();
        probe("c.tl",  11'd100, 11'd200, 1'b1, 1'b1, 6'd0,  SPR, 1'b1);
        probe("c.br",  11'd137, 11'd239, 1'b1, 1'b1, 6'd39, SPR, 1'b1);
        probe("c.odd", 11'd101, 11'd200, 1'b1, 1'b1, 6'd0,  BG,  1'b0);
        probe("c.l",   11'd99,  11'd200, 1'b1, 1'b0, 6'd0,  BG,  1'b0);
        probe("c.r",   11'd138, 11'd200, 1'b1, 1'b0, 6'd0,  BG,  1'b0);

        load(11'd500, 11'd500, 1'b0);
        load(11'd510, 11'd400, 1'b0);
        load(11'd500, 11'd500, 1'b0);
        probe("db.old", 11'd100, 11'd200, 1'b1, 1'b1, 6'd0, SPR, 1'b1);
        probe("db.new0", 11'd500, 11'd500, 1'b1, 1'b0, 6'd0, BG, 1'b0);
        tick();
        probe("db.new", 11'd500, 11'd501, 1'b1, 1'b1, 6'd1, BG, 1'b0);
        probe("db.new2", 11'd501, 11'd501, 1'b1, 1'b1, 6'd1, SPR, 1'b1);

        // Simultaneous load and tick applies at once
        load(11'd300, 11'd300, 1'b1);
        probe("same", 11'd300, 11'd300, 1'b1, 1'b1, 6'd0, SPR, 1'b1);

        // Saturation to (1242,984)
        load(11'd1279, 11'd1023, 1'b1);
        probe("sat.tl",  11'd1242, 11'd984,  1'b1, 1'b1, 6'd0,  SPR, 1'b1);
        probe("sat.br",  11'd1279, 11'd1023, 1'b1, 1'b1, 6'd39, SPR, 1'b1);
        probe("sat.x",   11'd1280, 11'd1023, 1'b1, 1'b1, 6'd39, BG,  1'b0);
        probe("sat.l",   11'd1241, 11'd984,  1'b1, 1'b0, 6'd0,  BG,  1'b0);
        probe("wrap",    11'd0,    11'd984,  1'b1, 1'b0, 6'd0,  BG,  1'b0);

        // Blanking inside the box
        probe("blank", 11'd1242, 11'd984, 1'b0, 1'b1, 6'd39, 12'h000, 1'b0);

        // Sync delay scoreboard
        for (int i = 0; i < 2000; i++) begin
            hsync_in = 1'($urandom);
            vsync_in = 1'($urandom);
            hs_hist.push_back(hsync_in);
            vs_hist.push_back(vsync_in);
            step();
            if (i >= 1) begin
                check("sb.hs", 32'(hsync_out), 32'(hs_hist[0]));
                check("sb.vs", 32'(vsync_out), 32'(vs_hist[0]));
                void'(hs_hist.pop_front());
                void'(vs_hist.pop_front());
            end
        end

        // Mid-frame reset during a sprite row
        hsync_in = 1'b1; vsync_in = 1'b1;
        pixel_x = 11'd1243; pixel_y = 11'd985; video_on = 1'b1;
        step();
        step();
        check("mr.pre.addr", 32'(rom_addr), 32'd1);
        check("mr.pre.hs", 32'(hsync_out), 32'h1);
        rst = 1'b1;
        step();
        check("mr.rgb", 32'(rgb), 32'h0);
        check("mr.on", 32'(sprite_on), 32'h0);
        check("mr.addr", 32'(rom_addr), 32'h0);
        check("mr.hs", 32'(hsync_out), 32'h0);
        check("mr.vs", 32'(vsync_out), 32'h0);
        rst = 1'b0;
        hsync_in = 1'b0; vsync_in = 1'b0;
        probe("mr.init", 11'd622, 11'd493, 1'b1, 1'b1, 6'd1, SPR, 1'b1);
        probe("mr.old",  11'd1242, 11'd984, 1'b1, 1'b0, 6'd0, BG, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
